// File: rtl/execute_multdiv_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
interface execute_multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_mult;
    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_mult, ctrl_div, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_mult, ctrl_div, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/execute_multdiv.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle,
// fixed 33-cycle latency from start edge to the end of the result pulse.
module execute_multdiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    execute_multdiv_if.slave  mdu
);
    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             neg_q, neg_d, dz_q, dz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     m_sum;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH:0]     d_rs;
    logic [WIDTH-1:0]   d_diff, d_hi, d_lo, quo;
    logic               d_ge;

    assign mag_a = mdu.data_operandA[WIDTH-1] ? -mdu.data_operandA : mdu.data_operandA;
    assign mag_b = mdu.data_operandB[WIDTH-1] ? -mdu.data_operandB : mdu.data_operandB;

    // Multiply step: hi/lo form a 64-bit accumulator whose low half shifts out the multiplier.
    assign m_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign prod   = {m_sum, lo_q[WIDTH-1:1]};
    assign prod_s = neg_q ? -prod : prod;

    // Divide step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    assign d_rs   = {hi_q, lo_q[WIDTH-1]};
    assign d_ge   = d_rs >= {1'b0, opnd_q};
    assign d_diff = d_rs[WIDTH-1:0] - opnd_q;
    assign d_hi   = d_ge ? d_diff : d_rs[WIDTH-1:0];
    assign d_lo   = {lo_q[WIDTH-2:0], d_ge};
    assign quo    = neg_q ? -d_lo : d_lo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        exc_d   = exc_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (mdu.ctrl_mult || mdu.ctrl_div) begin
                    state_d = mdu.ctrl_mult ? StMult : StDiv;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = mdu.ctrl_mult ? mag_b : mag_a;
                    opnd_d  = mdu.ctrl_mult ? mag_a : mag_b;
                    neg_d   = mdu.data_operandA[WIDTH-1] ^ mdu.data_operandB[WIDTH-1];
                    dz_d    = mdu.data_operandB == '0;
                    ovf_d   = (mdu.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                              (mdu.data_operandB == {WIDTH{1'b1}});
                end
            end
            StMult: begin
                hi_d  = m_sum[WIDTH:1];
                lo_d  = prod[WIDTH-1:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                    cnt_d   = cnt_q;
                    res_d   = prod_s[WIDTH-1:0];
                    exc_d   = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
                end
            end
            StDiv: begin
                hi_d  = d_hi;
                lo_d  = d_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                    cnt_d   = cnt_q;
                    res_d   = dz_q ? '0 : quo;
                    exc_d   = dz_q || ovf_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign mdu.data_result    = res_q;
    assign mdu.data_exception = exc_q;
    assign mdu.data_resultRDY = state_q == StDone;
    assign mdu.busy           = (state_q == StMult) || (state_q == StDiv);
endmodule
